led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter PwmBits, default 8, brightness and duty width; legal range 2..16.
REQ-002 SHALL have parameter StepCycles, default 4, clock cycles per brightness step; legal range >= 1.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port level_i  input  1  requested LED level from the blinky stage; 1 = on.
REQ-006 SHALL have port pwm_o  output  1  PWM drive to the physical LED.
REQ-007 SHALL have port brightness_o  output  PwmBits  current brightness value.
REQ-008 SHALL have port busy_o  output  1  high while ramping (RISE or FALL).

Function
REQ-009 SHALL implement states OFF, RISE, ON and FALL; state changes SHALL take effect on the edge at which level_i is sampled.
REQ-010 From OFF, level_i=1 SHALL move the block to RISE; from ON, level_i=0 SHALL move it to FALL.
REQ-011 In RISE, level_i=0 SHALL move the block to FALL; in FALL, level_i=1 SHALL move it to RISE; brightness SHALL continue from its current value with no jump.
REQ-012 A prescaler SHALL clear on every state change and assert a step tick when it equals StepCycles-1, then wrap to 0.
REQ-013 The first step SHALL land StepCycles cycles after RISE or FALL entry.
REQ-014 In RISE, each tick SHALL increment brightness by 1; the tick that reaches 2^PwmBits-1 SHALL enter ON on the same edge.
REQ-015 In FALL, each tick SHALL decrement brightness by 1; the tick that reaches 0 SHALL enter OFF on the same edge.
REQ-016 FALL with brightness already 0 SHALL enter OFF on the next edge.
REQ-017 Brightness SHALL never wrap; it saturates at 0 and 2^PwmBits-1.
REQ-018 busy_o SHALL be 1 exactly in RISE and FALL, registered with the state.
REQ-019 The PWM counter SHALL run 0..2^PwmBits-2, period 2^PwmBits-1 cycles.
REQ-020 pwm_o SHALL be registered as (counter < active duty), so duty 0 is constant 0 and duty 2^PwmBits-1 is constant 1.
REQ-021 Active duty SHALL load from a shadow value only when the counter wraps to 0, so no partial-period glitch occurs.

Reset
REQ-022 While rst_i=1: state=OFF, brightness_o=0, busy_o=0, pwm_o=0, prescaler=0, PWM counter=0, active duty=0.
REQ-023 Reset asserted mid-ramp SHALL override all transitions on that edge.
REQ-024 After reset is released, level_i=1 SHALL restart RISE from 0.

Configuration
REQ-025 With LED_FADER_GAMMA_EN defined, shadow duty SHALL be (brightness*brightness) >> PwmBits, with full-width intermediate, except brightness 2^PwmBits-1 SHALL map to 2^PwmBits-1.
REQ-026 Without LED_FADER_GAMMA_EN, shadow duty SHALL equal brightness.
REQ-027 State and ramp timing SHALL be identical in both builds.

Structure
REQ-028 Package led_fader_pkg SHALL hold the state enum type and a default-PwmBits constant.
REQ-029 Sub-module led_fader_pwm SHALL hold the PWM counter, the shadow-to-active duty load and the pwm_o register.
REQ-030 Top-level led_fader SHALL hold the FSM, prescaler, brightness register and gamma mapping.

Verification (PwmBits=4, StepCycles=2)
REQ-031 rst_i high 2 cycles with level_i=1 -> pwm_o=0, brightness_o=0, busy_o=0 throughout; after release, RISE is entered and busy_o=1.
REQ-032 level_i held 1 from OFF -> brightness_o=1 two cycles after RISE entry and 15 thirty cycles after entry; busy_o falls on that edge; pwm_o is constant 1 from the next PWM wrap.
REQ-033 level_i deasserted when brightness_o=5 -> FALL next edge; brightness_o never exceeds 5; brightness reaches 0 ten cycles later; OFF state; busy_o=0.
REQ-034 Brightness held at 8 (gamma off) -> pwm_o high 8 of every 15 cycles; with LED_FADER_GAMMA_EN -> high 4 of every 15.
REQ-035 rst_i pulsed at brightness_o=7 in RISE with level_i=1 -> all outputs 0 on the next edge; after release, the ramp restarts from 0.
REQ-036 One-cycle level_i pulse in OFF -> RISE, then FALL, then OFF; brightness_o stays 0 and pwm_o stays 0.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared types and defaults for the LED fader: FSM state encoding and default widths.
// The optional gamma build is selected with LED_FADER_GAMMA_EN (see led_fader.sv).
package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_e;

    localparam int DEFAULT_PWM_BITS    = 8;
    localparam int DEFAULT_STEP_CYCLES = 4;

    // Width of a counter that must hold values 0..count-1 (at least one bit).
    function automatic int count_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/led_fader_pwm.sv
// PWM generator: free-running counter over 0..2^PwmBits-2, duty latched only at the
// period boundary so a duty change never produces a truncated or stretched pulse.
module led_fader_pwm #(
    parameter int PwmBits = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [PwmBits-1:0] duty_shadow,
    output logic               pwm
);

    // Last counter value; period is 2^PwmBits-1 so full-scale duty is a constant high.
    localparam logic [PwmBits-1:0] CNT_LAST = {{(PwmBits-1){1'b1}}, 1'b0};
    localparam logic [PwmBits-1:0] CNT_ONE  = PwmBits'(1);

    logic [PwmBits-1:0] cnt_reg;
    logic [PwmBits-1:0] cnt_next;
    logic [PwmBits-1:0] duty_active_reg;
    logic [PwmBits-1:0] duty_active_next;
    logic               pwm_reg;
    logic               pwm_next;
    logic               wrap;

    always_comb begin
        wrap             = (cnt_reg == CNT_LAST);
        cnt_next         = wrap ? '0 : (cnt_reg + CNT_ONE);
        duty_active_next = wrap ? duty_shadow : duty_active_reg;
        pwm_next         = (cnt_reg < duty_active_reg);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg         <= '0;
            duty_active_reg <= '0;
            pwm_reg         <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            duty_active_reg <= duty_active_next;
            pwm_reg         <= pwm_next;
        end
    end

    assign pwm = pwm_reg;

endmodule

// File: rtl/led_fader.sv
// LED fader top: OFF/RISE/ON/FALL ramp FSM, step prescaler, brightness register and
// duty mapping. Define LED_FADER_GAMMA_EN for a squared (gamma-corrected) duty curve.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int PwmBits    = DEFAULT_PWM_BITS,
    parameter int StepCycles = DEFAULT_STEP_CYCLES
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               level_i,
    output logic               pwm_o,
    output logic [PwmBits-1:0] brightness_o,
    output logic               busy_o
);

    localparam int                  PRESC_W     = count_width(StepCycles);
    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(StepCycles - 1);
    localparam logic [PRESC_W-1:0]  PRESC_ONE   = PRESC_W'(1);
    localparam logic [PwmBits-1:0]  BRIGHT_MAX  = {PwmBits{1'b1}};
    localparam logic [PwmBits-1:0]  BRIGHT_ONE  = PwmBits'(1);
    localparam logic [PwmBits-1:0]  BRIGHT_LAST = BRIGHT_MAX - BRIGHT_ONE;

    state_e             state_reg;
    state_e             state_next;
    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] presc_next;
    logic [PwmBits-1:0] brightness_reg;
    logic [PwmBits-1:0] brightness_next;
    logic               busy_reg;
    logic               busy_next;
    logic               step_tick;
    logic [PwmBits-1:0] duty_shadow;

    // State register: FSM state, prescaler, brightness and busy flag update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_OFF;
            presc_reg      <= '0;
            brightness_reg <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            brightness_reg <= brightness_next;
            busy_reg       <= busy_next;
        end
    end

    // Next-state logic. A ramp reversal keeps the current brightness; only the
    // tick that lands on an end value completes the ramp, on that same edge.
    always_comb begin
        state_next      = state_reg;
        brightness_next = brightness_reg;
        step_tick       = (presc_reg == PRESC_LAST);

        unique case (state_reg)
            ST_OFF: begin
                if (level_i) state_next = ST_RISE;
            end
            ST_RISE: begin
                if (!level_i) begin
                    state_next = ST_FALL;
                end else if (step_tick) begin
                    if (brightness_reg == BRIGHT_LAST || brightness_reg == BRIGHT_MAX) begin
                        brightness_next = BRIGHT_MAX;
                        state_next      = ST_ON;
                    end else begin
                        brightness_next = brightness_reg + BRIGHT_ONE;
                    end
                end
            end
            ST_ON: begin
                if (!level_i) state_next = ST_FALL;
            end
            ST_FALL: begin
                if (level_i) begin
                    state_next = ST_RISE;
                end else if (brightness_reg == '0) begin
                    state_next = ST_OFF;
                end else if (step_tick) begin
                    brightness_next = brightness_reg - BRIGHT_ONE;
                    if (brightness_reg == BRIGHT_ONE) state_next = ST_OFF;
                end
            end
            default: state_next = ST_OFF;
        endcase

        // Prescaler restarts on every state change so the first step lands
        // StepCycles cycles after entering a ramp; it idles at 0 when not ramping.
        if (state_next != state_reg || step_tick ||
            state_reg == ST_OFF || state_reg == ST_ON) begin
            presc_next = '0;
        end else begin
            presc_next = presc_reg + PRESC_ONE;
        end
    end

    // Output logic: busy follows the next state so it is registered alongside it,
    // and the shadow duty is derived from the registered brightness.
`ifdef LED_FADER_GAMMA_EN
    logic [2*PwmBits-1:0] bright_sq;
`endif

    always_comb begin
        busy_next = (state_next == ST_RISE) || (state_next == ST_FALL);
`ifdef LED_FADER_GAMMA_EN
        bright_sq = {{PwmBits{1'b0}}, brightness_reg} * {{PwmBits{1'b0}}, brightness_reg};
        if (brightness_reg == BRIGHT_MAX) begin
            duty_shadow = BRIGHT_MAX;
        end else begin
            duty_shadow = bright_sq[2*PwmBits-1:PwmBits];
        end
`else
        duty_shadow = brightness_reg;
`endif
    end

    led_fader_pwm #(
        .PwmBits(PwmBits)
    ) u_pwm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .duty_shadow(duty_shadow),
        .pwm        (pwm_o)
    );

    assign brightness_o = brightness_reg;
    assign busy_o       = busy_reg;

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with PwmBits=4, StepCycles=2; expected values are
// hand-derived from the ramp timing and PWM period (15 cycles).
module tb_led_fader;

    localparam int PWM_BITS    = 4;
    localparam int STEP_CYCLES = 2;

`ifdef LED_FADER_GAMMA_EN
    localparam int DUTY_AT_8 = 4;
`else
    localparam int DUTY_AT_8 = 8;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic                level_i = 1'b1;
    logic                pwm_o;
    logic [PWM_BITS-1:0] brightness_o;
    logic                busy_o;

    int total = 0;
    int bad   = 0;

    led_fader #(
        .PwmBits   (PWM_BITS),
        .StepCycles(STEP_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .level_i     (level_i),
        .pwm_o       (pwm_o),
        .brightness_o(brightness_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int highs;
        int bmax;
        int bmin;
        int pwm_seen;

        // Reset held two cycles with level_i=1
        step(1);
        check("rst1_pwm", pwm_o, 0);
        check("rst1_bright", brightness_o, 0);
        check("rst1_busy", busy_o, 0);
        step(1);
        check("rst2_pwm", pwm_o, 0);
        check("rst2_bright", brightness_o, 0);
        check("rst2_busy", busy_o, 0);

        // Release: RISE entry edge E0
        rst_i = 1'b0;
        step(1);
        check("rise_entry_busy", busy_o, 1);
        check("rise_entry_bright", brightness_o, 0);
        step(1);
        check("rise_e1_bright", brightness_o, 0);
        step(1);
        check("rise_e2_bright", brightness_o, 1);
        step(27);
        check("rise_e29_bright", brightness_o, 14);
        check("rise_e29_busy", busy_o, 1);
        step(1);
        check("rise_e30_bright", brightness_o, 15);
        check("rise_e30_busy", busy_o, 0);

        // Full scale: pwm constant high once the next period has loaded
        step(17);
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            highs += int'(pwm_o);
            step(1);
        end
        check("on_pwm_highs", highs, 15);

        // Reverse at brightness 5
        rst_i = 1'b1;
        step(1);
        check("rst_b_bright", brightness_o, 0);
        rst_i   = 1'b0;
        level_i = 1'b1;
        step(1);
        step(10);
        check("rev_at5_bright", brightness_o, 5);
        level_i = 1'b0;
        step(1);
        check("fall_entry_busy", busy_o, 1);
        check("fall_entry_bright", brightness_o, 5);
        bmax = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (int'(brightness_o) > bmax) bmax = int'(brightness_o);
        end
        check("fall_max_bright", bmax, 5);
        check("fall_f10_bright", brightness_o, 0);
        check("fall_f10_busy", busy_o, 0);
        step(3);
        check("off_idle_busy", busy_o, 0);

        // Hold brightness at 8 by alternating level_i each cycle
        level_i = 1'b1;
        step(1);
        step(16);
        check("hold_start_bright", brightness_o, 8);
        bmin  = 15;
        bmax  = 0;
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            level_i = ~level_i;
            step(1);
            if (int'(brightness_o) > bmax) bmax = int'(brightness_o);
            if (int'(brightness_o) < bmin) bmin = int'(brightness_o);
            if (i >= 16 && i < 31) highs += int'(pwm_o);
        end
        check("hold_max_bright", bmax, 8);
        check("hold_min_bright", bmin, 8);
        check("hold_busy", busy_o, 1);
        check("hold_pwm_highs", highs, DUTY_AT_8);

        // Reset mid-ramp at brightness 7
        rst_i = 1'b1;
        step(1);
        rst_i   = 1'b0;
        level_i = 1'b1;
        step(1);
        step(14);
        check("mid_pre_bright", brightness_o, 7);
        check("mid_pre_busy", busy_o, 1);
        rst_i = 1'b1;
        step(1);
        check("mid_rst_bright", brightness_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_pwm", pwm_o, 0);
        rst_i = 1'b0;
        step(1);
        check("restart_busy", busy_o, 1);
        check("restart_bright0", brightness_o, 0);
        step(2);
        check("restart_bright1", brightness_o, 1);

        // One-cycle level pulse from OFF
        rst_i   = 1'b1;
        level_i = 1'b0;
        step(1);
        rst_i = 1'b0;
        step(2);
        check("pulse_idle_busy", busy_o, 0);
        pwm_seen = 0;
        level_i  = 1'b1;
        step(1);
        pwm_seen |= int'(pwm_o);
        check("pulse_rise_busy", busy_o, 1);
        level_i = 1'b0;
        step(1);
        pwm_seen |= int'(pwm_o);
        check("pulse_fall_busy", busy_o, 1);
        check("pulse_fall_bright", brightness_o, 0);
        step(1);
        pwm_seen |= int'(pwm_o);
        check("pulse_off_busy", busy_o, 0);
        check("pulse_off_bright", brightness_o, 0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            pwm_seen |= int'(pwm_o);
        end
        check("pulse_pwm_low", pwm_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
